// File: rtl/selector.sv
// Operation selector shared by the pipeline decode and the multiply/divide unit.
package selector;

    typedef enum logic [1:0] {
        MULDIV_MULT  = 2'b00,
        MULDIV_MULTU = 2'b01,
        MULDIV_DIV   = 2'b10,
        MULDIV_DIVU  = 2'b11
    } muldiv_funct_t;

    function automatic logic funct_is_div(input muldiv_funct_t f);
        return (f == MULDIV_DIV) || (f == MULDIV_DIVU);
    endfunction

    function automatic logic funct_is_signed(input muldiv_funct_t f);
        return (f == MULDIV_MULT) || (f == MULDIV_DIV);
    endfunction

endpackage

// File: rtl/signals.sv
// Shared control-signal types: multiply/divide sequencer states.
package signals;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division iteration on unsigned magnitudes (combinational).
module div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[W-1]};
        diff    = shifted - {1'b0, divisor_i};
        // diff[W] acts as the borrow: the partial remainder never exceeds 2*divisor
        if (!diff[W]) begin
            rem_o = diff[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b1};
        end else begin
            rem_o = shifted[W-1:0];
            quo_o = {quo_i[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 HI/LO multiply/divide unit (W cycles per operation).
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with zero.
module muldiv_unit
    import selector::*;
    import signals::*;
#(
    parameter int unsigned W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  muldiv_funct_t funct,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  hi,
    output logic [W-1:0]  lo
);

    localparam int unsigned     CntW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(W - 1);

    muldiv_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    acc_q, acc_d;  // product high half, or partial remainder
    logic [W-1:0]    ops_q, ops_d;  // multiplier/product low half, or dividend/quotient
    logic [W-1:0]    opb_q, opb_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;

    logic            sgn_a, sgn_b;
    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      mul_sum;
    logic [W-1:0]    mul_acc, mul_ops;
    logic [W-1:0]    step_acc, step_ops;
    logic [2*W-1:0]  prod_res;
    logic [2*W-1:0]  res;

    always_comb begin
        sgn_a = funct_is_signed(funct) & a[W-1];
        sgn_b = funct_is_signed(funct) & b[W-1];
        abs_a = sgn_a ? -a : a;
        abs_b = sgn_b ? -b : b;
    end

    always_comb begin
        mul_sum = {1'b0, acc_q} + (ops_q[0] ? {1'b0, opb_q} : '0);
        mul_acc = mul_sum[W:1];
        mul_ops = {mul_sum[0], ops_q[W-1:1]};
    end

`ifdef MULDIV_DIV_EN
    logic         div_q, div_d;
    logic [W-1:0] div_rem, div_quo;
    logic [W-1:0] quo_res, rem_res;

    div_step #(
        .W (W)
    ) u_div_step (
        .rem_i     (acc_q),
        .quo_i     (ops_q),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    always_comb begin
        step_acc = div_q ? div_rem : mul_acc;
        step_ops = div_q ? div_quo : mul_ops;
        // Zero divisor leaves the dividend in the remainder; only the quotient needs forcing
        quo_res  = (opb_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -step_ops : step_ops);
        rem_res  = neg_a_q ? -step_acc : step_acc;
    end
`else
    always_comb begin
        step_acc = mul_acc;
        step_ops = mul_ops;
    end
`endif

    always_comb begin
        prod_res = (neg_a_q ^ neg_b_q) ? -{step_acc, step_ops} : {step_acc, step_ops};
`ifdef MULDIV_DIV_EN
        res      = div_q ? {rem_res, quo_res} : prod_res;
`else
        res      = prod_res;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ops_d   = ops_q;
        opb_d   = opb_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MULDIV_DIV_EN
        div_d   = div_q;
`endif

        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StRun;
                        cnt_d   = '0;
                        acc_d   = '0;
                        ops_d   = abs_a;
                        opb_d   = abs_b;
                        neg_a_d = sgn_a;
                        neg_b_d = sgn_b;
`ifdef MULDIV_DIV_EN
                        div_d   = funct_is_div(funct);
`else
                        if (funct_is_div(funct)) begin
                            state_d = StDone;
                            hi_d    = '0;
                            lo_d    = '0;
                        end
`endif
                    end
                end
                StRun: begin
                    acc_d = step_acc;
                    ops_d = step_ops;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                        hi_d    = res[2*W-1:W];
                        lo_d    = res[W-1:0];
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            ops_q   <= '0;
            opb_q   <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULDIV_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ops_q   <= ops_d;
            opb_q   <= opb_d;
            neg_a_q <= neg_a_d;
            neg_b_q <= neg_b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MULDIV_DIV_EN
            div_q   <= div_d;
`endif
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases and random operations compared against
// plain 64-bit arithmetic; timing checks for flush, ignored start and async reset.
module tb_muldiv_unit;
    import selector::*;

    localparam int unsigned W   = 32;
    localparam int          Lat = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    muldiv_funct_t funct;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [63:0]   last_hilo;

    muldiv_unit #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .funct (funct),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result as {hi, lo}
    function automatic logic [63:0] ref_result(input muldiv_funct_t f, input logic [31:0] x,
                                               input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      p;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = 64'd0;
        case (f)
            MULDIV_MULT: begin
                p = sx * sy;
                r = p;
            end
            MULDIV_MULTU: r = {32'd0, x} * {32'd0, y};
            default: begin
`ifdef MULDIV_DIV_EN
                longint q;
                longint rm;
                if (y == 32'd0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else if (f == MULDIV_DIVU) begin
                    r = {x % y, x / y};
                end else begin
                    q  = sx / sy;
                    rm = sx % sy;
                    r  = {rm[31:0], q[31:0]};
                end
`else
                r = 64'd0;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input muldiv_funct_t f);
`ifdef MULDIV_DIV_EN
        return (f == MULDIV_DIV) ? Lat : Lat;
`else
        return ((f == MULDIV_DIV) || (f == MULDIV_DIVU)) ? 1 : Lat;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    // Starts an operation in the current cycle and checks latency, busy, result and hold
    task automatic run_op(input muldiv_funct_t f, input logic [31:0] opa, input logic [31:0] opb,
                          input string tag);
        logic [63:0] expv;
        int          cyc;
        int          busy_low;
        expv  = ref_result(f, opa, opb);
        funct = f;
        a     = opa;
        b     = opb;
        start = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        busy_low = 0;
        while (!done && cyc < 40) begin
            if (!busy) busy_low++;
            tick();
            cyc++;
        end
        if (!busy) busy_low++;
        check({tag, "/latency"}, 64'(cyc), 64'(exp_latency(f)));
        check({tag, "/busy"}, 64'(busy_low), 64'd0);
        check({tag, "/result"}, {hi, lo}, expv);
        tick();
        check({tag, "/idle"}, {62'd0, done, busy}, 64'd0);
        check({tag, "/hold"}, {hi, lo}, expv);
        last_hilo = expv;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]   expv;
        int            cyc;
        int            ndone;
        int            done_cyc;
        muldiv_funct_t rf;

        rst_n     = 1'b0;
        start     = 1'b0;
        flush     = 1'b0;
        funct     = MULDIV_MULT;
        a         = '0;
        b         = '0;
        last_hilo = 64'd0;
        tick();
        tick();
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        run_op(MULDIV_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(MULDIV_MULT,  32'hFFFF_FFFD, 32'd5,         "mult_neg");
        run_op(MULDIV_DIV,   32'hFFFF_FFF9, 32'd2,         "div_neg");
        run_op(MULDIV_DIVU,  32'd7,         32'd0,         "divu_zero");
        run_op(MULDIV_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(MULDIV_DIV,   32'hFFFF_FF00, 32'd0,         "div_zero_neg");
        run_op(MULDIV_DIV,   32'd100,       32'hFFFF_FFF9, "div_pos_neg");
        run_op(MULDIV_MULT,  32'h8000_0000, 32'h8000_0000, "mult_min");
        run_op(MULDIV_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, "divu_big");

        for (int i = 0; i < 40; i++) begin
            rf = muldiv_funct_t'(2'($urandom_range(0, 3)));
            run_op(rf, pick_operand(), pick_operand(), "random");
        end

        // Flush during RUN at cycle 10
        funct = MULDIV_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        ndone = 0;
        while (cyc < 10) begin
            if (done) ndone++;
            tick();
            cyc++;
        end
        if (done) ndone++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        if (done) ndone++;
        check("flush/busy", 64'(busy), 64'd0);
        check("flush/no_done", 64'(ndone), 64'd0);
        check("flush/hilo", {hi, lo}, last_hilo);
        tick();
        run_op(MULDIV_MULTU, 32'd2, 32'd3, "post_flush");

        // Flush and start together in IDLE
        funct = MULDIV_MULT;
        a     = 32'd11;
        b     = 32'd13;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_start/busy", 64'(busy), 64'd0);
        tick();
        check("flush_start/quiet", {62'd0, done, busy}, 64'd0);
        check("flush_start/hilo", {hi, lo}, last_hilo);

        // Second start while busy must be dropped
        expv     = ref_result(MULDIV_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        funct    = MULDIV_MULTU;
        a        = 32'h1234_5678;
        b        = 32'h9ABC_DEF0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        cyc      = 1;
        ndone    = 0;
        done_cyc = 0;
        while (cyc < 45) begin
            if (cyc == 5) begin
                start = 1'b1;
                funct = MULDIV_MULT;
                a     = 32'd7;
                b     = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("busy_start/done_count", 64'(ndone), 64'd1);
        check("busy_start/done_cycle", 64'(done_cyc), 64'(Lat));
        check("busy_start/result", {hi, lo}, expv);
        last_hilo = expv;

        // Asynchronous reset in the middle of an operation
`ifdef MULDIV_DIV_EN
        funct = MULDIV_DIV;
`else
        funct = MULDIV_MULTU;
`endif
        a     = 32'hFFFF_FF9C;
        b     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 20) begin
            tick();
            cyc++;
        end
        check("pre_reset/busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset/busy", 64'(busy), 64'd0);
        check("async_reset/done", 64'(done), 64'd0);
        check("async_reset/hilo", {hi, lo}, 64'd0);
        tick();
        rst_n = 1'b1;
        run_op(MULDIV_MULT, 32'hFFFF_FFFD, 32'd5, "after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
